instr_fetch: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the MIPS pipeline. Holds the program counter, fetches one word per request from instruction memory over a req/ack handshake, and presents `Instruction_Code` and `PC_if_id` to the decode stage. Supports decode stall, flush, and PC redirect for jumps and branches. Redirect arrives from decode or execute.

---
 rtl/instr_fetch.sv | 180 ++++++++++++++++++
 tb/tb_instr_fetch.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Keeps the program counter and fetches one word per request from instruction
// memory. It drives the fetched word and its address+4 to decode, and handles
// decode stall, flush and PC redirects from the later stages.
//
// Memory handshake: imem_req is high only in REQ and DROP. While imem_req is
// high, imem_addr does not change until a cycle in which imem_ack is sampled
// high at the rising edge. That edge completes the transfer, and imem_rdata is
// taken in the same cycle. imem_ack is ignored whenever imem_req is low. An ack
// in the first cycle of a request is legal.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_Code,
  output logic [31:0] PC_if_id,
  output logic        if_id_valid
);

  // IDLE: leaving reset. REQ: request outstanding. HOLD: word parked while
  // decode stalls. DROP: a stale request must complete before the target is fetched.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;          // next address to fetch (saved target while in DROP)
  logic [31:0] buf_instr;   // word accepted from memory while decode stalled
  logic [31:0] buf_pc;      // its address + 4
  logic [31:0] target;
  logic [31:0] pc_next;
  logic [31:0] addr_next;
  logic        unused_redirect_lsbs;

  // Redirect targets are forced to a word boundary.
  assign target               = {redirect_pc[31:2], 2'b00};
  assign pc_next              = pc + 32'd4;
  assign addr_next            = imem_addr + 32'd4;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Fetch FSM: the next state, pc, memory request and IF/ID register are all registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      imem_req         <= 1'b0;
      imem_addr        <= RESET_PC;
      Instruction_Code <= NOP_WORD;
      PC_if_id         <= 32'h0000_0000;
      if_id_valid      <= 1'b0;
      buf_instr        <= NOP_WORD;
      buf_pc           <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            pc        <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc;
          end
          if (redirect_valid || flush) begin
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
          end
        end

        REQ: begin
          if (redirect_valid) begin
            // The in-flight word is useless. Finish the stale request in DROP unless it completes now.
            pc               <= target;
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
            if (imem_ack) begin
              imem_addr <= target;
            end else begin
              state <= DROP;
            end
          end else if (flush) begin
            // Squash decode. A word arriving now is thrown away, but fetch still moves on.
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
            if (imem_ack) begin
              pc        <= pc_next;
              imem_addr <= pc_next;
            end
          end else if (stall) begin
            // Decode is busy. Park the arriving word and pause fetching.
            if (imem_ack) begin
              buf_instr <= imem_rdata;
              buf_pc    <= addr_next;
              state     <= HOLD;
              imem_req  <= 1'b0;
            end
          end else if (imem_ack) begin
            Instruction_Code <= imem_rdata;
            PC_if_id         <= addr_next;
            if_id_valid      <= 1'b1;
            pc               <= pc_next;
            imem_addr        <= pc_next;
          end else begin
            // Nothing arrived: present a bubble and keep the last PC_if_id.
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc               <= target;
            imem_addr        <= target;
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
            state            <= REQ;
            imem_req         <= 1'b1;
          end else if (flush) begin
            // The parked word is squashed. Fetching resumes after it.
            pc               <= pc_next;
            imem_addr        <= pc_next;
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
            state            <= REQ;
            imem_req         <= 1'b1;
          end else if (!stall) begin
            Instruction_Code <= buf_instr;
            PC_if_id         <= buf_pc;
            if_id_valid      <= 1'b1;
            pc               <= pc_next;
            imem_addr        <= pc_next;
            state            <= REQ;
            imem_req         <= 1'b1;
          end
        end

        DROP: begin
          // imem_addr keeps the stale address until its ack; pc holds the target.
          if (redirect_valid) begin
            pc               <= target;
            Instruction_Code <= NOP_WORD;
            if_id_valid      <= 1'b0;
            if (imem_ack) begin
              imem_addr <= target;
              state     <= REQ;
            end
          end else begin
            if (flush || !stall) begin
              Instruction_Code <= NOP_WORD;
              if_id_valid      <= 1'b0;
            end
            if (imem_ack) begin
              imem_addr <= pc;
              state     <= REQ;
            end
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// latency/stall run scored against the in-order instruction stream.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] Instruction_Code;
  logic [31:0] PC_if_id;
  logic        if_id_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // Memory responder settings. mem_lat is the number of request cycles including the ack cycle.
  // A value of 0 selects a random latency of 1..3 cycles.
  int   mem_lat = 1;
  int   cur_lat = 1;
  int   wait_cnt = 0;
  logic force_ack = 1'b0;

  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  instr_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .Instruction_Code (Instruction_Code),
    .PC_if_id         (PC_if_id),
    .if_id_valid      (if_id_valid)
  );

  // Instruction memory: returns addr ^ KEY after the configured latency.
  always @(negedge clk) begin
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      wait_cnt   = 0;
    end else if (imem_req) begin
      if (wait_cnt == 0) cur_lat = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
      if (wait_cnt >= cur_lat - 1) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr ^ KEY;
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wait_cnt   = wait_cnt + 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      wait_cnt   = 0;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int lat);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0;
    force_ack = 1'b0; mem_lat = lat;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_lat = 1;
    tick(); tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      tests_failed++;
      $display("FAIL reset_mem: got req=%b addr=%h expected req=0 addr=0", imem_req, imem_addr);
    end
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {NOP, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ifid: got %h/%h/%b expected %h/0/0", Instruction_Code, PC_if_id, if_id_valid, NOP);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_reset(1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests_run++;
      if ({Instruction_Code, PC_if_id, if_id_valid, imem_addr} !==
          {(32'(4*k - 4)) ^ KEY, 32'(4*k), 1'b1, 32'(4*k)}) begin
        tests_failed++;
        $display("FAIL zero_wait_%0d: got %h/%h/%b addr=%h expected %h/%h/1 addr=%h", k,
                 Instruction_Code, PC_if_id, if_id_valid, imem_addr,
                 (32'(4*k - 4)) ^ KEY, 32'(4*k), 32'(4*k));
      end
    end
  endtask

  task automatic test_latency3();
    do_reset(3);
    for (int ld = 0; ld < 2; ld++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        tests_run++;
        if (j < 2) begin
          if ({imem_req, imem_addr, Instruction_Code, if_id_valid} !== {1'b1, 32'(4*ld), NOP, 1'b0}) begin
            tests_failed++;
            $display("FAIL lat3_wait_%0d_%0d: got req=%b addr=%h %h/%b expected req=1 addr=%h %h/0",
                     ld, j, imem_req, imem_addr, Instruction_Code, if_id_valid, 32'(4*ld), NOP);
          end
        end else begin
          if ({Instruction_Code, PC_if_id, if_id_valid} !== {(32'(4*ld)) ^ KEY, 32'(4*ld + 4), 1'b1}) begin
            tests_failed++;
            $display("FAIL lat3_load_%0d: got %h/%h/%b expected %h/%h/1", ld,
                     Instruction_Code, PC_if_id, if_id_valid, (32'(4*ld)) ^ KEY, 32'(4*ld + 4));
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    int n;
    do_reset(2);
    n = 0;
    while (!(if_id_valid && PC_if_id == 32'h10) && n < 30) begin tick(); n++; end
    tests_run++;
    if (n >= 30) begin
      tests_failed++;
      $display("FAIL stall_reach: got timeout expected PC_if_id=00000010");
    end
    stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      tick();
      tests_run++;
      if ({Instruction_Code, PC_if_id, if_id_valid} !== {32'h0C ^ KEY, 32'h10, 1'b1}) begin
        tests_failed++;
        $display("FAIL stall_hold_%0d: got %h/%h/%b expected %h/00000010/1", s,
                 Instruction_Code, PC_if_id, if_id_valid, 32'h0C ^ KEY);
      end
      if (s >= 1) begin
        tests_run++;
        if (imem_req !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_req_%0d: got req=%b expected req=0", s, imem_req);
        end
      end
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid, imem_req, imem_addr} !==
        {32'h10 ^ KEY, 32'h14, 1'b1, 1'b1, 32'h14}) begin
      tests_failed++;
      $display("FAIL stall_release: got %h/%h/%b req=%b addr=%h expected %h/00000014/1 req=1 addr=00000014",
               Instruction_Code, PC_if_id, if_id_valid, imem_req, imem_addr, 32'h10 ^ KEY);
    end
  endtask

  task automatic test_redirect_drop();
    int n;
    do_reset(3);
    n = 0;
    while (!(imem_req && imem_addr == 32'h20) && n < 60) begin tick(); n++; end
    tests_run++;
    if (n >= 60) begin
      tests_failed++;
      $display("FAIL redir_reach: got timeout expected imem_addr=00000020");
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0402;
    tick();
    redirect_valid = 1'b0; redirect_pc = $urandom;
    for (int j = 0; j < 2; j++) begin
      tests_run++;
      if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
        tests_failed++;
        $display("FAIL redir_drop_%0d: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000020",
                 j, if_id_valid, imem_req, imem_addr);
      end
      tick();
    end
    tests_run++;
    if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h400}) begin
      tests_failed++;
      $display("FAIL redir_target: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000400",
               if_id_valid, imem_req, imem_addr);
    end
    tick(); tick();
    tests_run++;
    if (if_id_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_gap: got valid=%b expected valid=0", if_id_valid);
    end
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {32'h400 ^ KEY, 32'h404, 1'b1}) begin
      tests_failed++;
      $display("FAIL redir_load: got %h/%h/%b expected %h/00000404/1",
               Instruction_Code, PC_if_id, if_id_valid, 32'h400 ^ KEY);
    end
  endtask

  task automatic test_flush();
    do_reset(1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests_run++;
    if ({Instruction_Code, if_id_valid, imem_addr} !== {NOP, 1'b0, 32'h8}) begin
      tests_failed++;
      $display("FAIL flush_req: got %h/%b addr=%h expected %h/0 addr=00000008",
               Instruction_Code, if_id_valid, imem_addr, NOP);
    end
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {32'h8 ^ KEY, 32'hC, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_resume: got %h/%h/%b expected %h/0000000c/1",
               Instruction_Code, PC_if_id, if_id_valid, 32'h8 ^ KEY);
    end
    stall = 1'b1;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    tests_run++;
    if ({if_id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
      tests_failed++;
      $display("FAIL flush_hold: got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000010",
               if_id_valid, imem_req, imem_addr);
    end
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {32'h10 ^ KEY, 32'h14, 1'b1}) begin
      tests_failed++;
      $display("FAIL flush_hold_resume: got %h/%h/%b expected %h/00000014/1",
               Instruction_Code, PC_if_id, if_id_valid, 32'h10 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if ({if_id_valid, imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
      tests_failed++;
      $display("FAIL wrap_target: got valid=%b addr=%h expected valid=0 addr=fffffffc", if_id_valid, imem_addr);
    end
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid, imem_addr} !== {32'hFFFF_FFFC ^ KEY, 32'h0, 1'b1, 32'h0}) begin
      tests_failed++;
      $display("FAIL wrap_load: got %h/%h/%b addr=%h expected %h/00000000/1 addr=00000000",
               Instruction_Code, PC_if_id, if_id_valid, imem_addr, 32'hFFFF_FFFC ^ KEY);
    end
    tick();
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {KEY, 32'h4, 1'b1}) begin
      tests_failed++;
      $display("FAIL wrap_next: got %h/%h/%b expected %h/00000004/1", Instruction_Code, PC_if_id, if_id_valid, KEY);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset(4);
    n = 0;
    while (!if_id_valid && n < 12) begin tick(); n++; end
    tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if ({imem_req, imem_addr, Instruction_Code, PC_if_id, if_id_valid} !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid: got req=%b addr=%h %h/%h/%b expected req=0 addr=0 %h/0/0",
               imem_req, imem_addr, Instruction_Code, PC_if_id, if_id_valid, NOP);
    end
    force_ack = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    force_ack = 1'b0;
    tests_run++;
    if ({imem_req, imem_addr, Instruction_Code, if_id_valid} !== {1'b1, 32'h0, NOP, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_late_ack: got req=%b addr=%h %h/%b expected req=1 addr=0 %h/0",
               imem_req, imem_addr, Instruction_Code, if_id_valid, NOP);
    end
    n = 0;
    while (!if_id_valid && n < 12) begin tick(); n++; end
    tests_run++;
    if ({Instruction_Code, PC_if_id, if_id_valid} !== {KEY, 32'h4, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_restart: got %h/%h/%b expected %h/00000004/1", Instruction_Code, PC_if_id, if_id_valid, KEY);
    end
  endtask

  // Random latency and stall. Every new IF/ID entry must be the next word of the sequential stream.
  task automatic test_random();
    logic [31:0] p_instr, p_pc, p_addr, e_addr;
    logic        p_valid, p_req, p_ack, p_stall;
    int          loads;
    loads = 0;
    do_reset(0);
    exp_q.delete();
    for (int i = 0; i < 500; i++) exp_q.push_back(32'(i * 4));
    for (int cyc = 0; cyc < 400; cyc++) begin
      stall = ($urandom_range(0, 3) == 0);
      @(negedge clk); #1;
      p_instr = Instruction_Code; p_pc = PC_if_id; p_valid = if_id_valid;
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr; p_stall = stall;
      tick();
      tests_run++;
      if (p_stall) begin
        if ({Instruction_Code, PC_if_id, if_id_valid} !== {p_instr, p_pc, p_valid}) begin
          tests_failed++;
          $display("FAIL rand_hold_%0d: got %h/%h/%b expected %h/%h/%b", cyc,
                   Instruction_Code, PC_if_id, if_id_valid, p_instr, p_pc, p_valid);
        end
      end else if (if_id_valid) begin
        e_addr = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        loads++;
        if ({Instruction_Code, PC_if_id} !== {e_addr ^ KEY, e_addr + 32'd4}) begin
          tests_failed++;
          $display("FAIL rand_load_%0d: got %h/%h expected %h/%h", cyc,
                   Instruction_Code, PC_if_id, e_addr ^ KEY, e_addr + 32'd4);
        end
      end else if (Instruction_Code !== NOP) begin
        tests_failed++;
        $display("FAIL rand_bubble_%0d: got %h expected %h", cyc, Instruction_Code, NOP);
      end
      if (p_req && !p_ack) begin
        tests_run++;
        if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
          tests_failed++;
          $display("FAIL rand_addr_stable_%0d: got req=%b addr=%h expected req=1 addr=%h",
                   cyc, imem_req, imem_addr, p_addr);
        end
      end
    end
    stall = 1'b0;
    tests_run++;
    if (loads < 50) begin
      tests_failed++;
      $display("FAIL rand_progress: got %0d loads expected at least 50", loads);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency3();
    test_stall();
    test_redirect_drop();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
